// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Time-shares one combinational ALU between NR_REQ issue
//                requesters. A round-robin scan picks at most one eligible
//                requester per cycle, drives its operation onto the ALU and
//                captures the ALU result into that requester's one-entry
//                response slot, returned over a valid/ready handshake.
//  Ports       : clk_i / rst_ni       clock, synchronous active-low reset
//                flush_i              drop all buffered results, no grant
//                req_*                per-requester operation + handshake
//                alu_*                shared ALU drive and result return
//                resp_*               per-requester registered response
//                ops_count_o          saturating count of granted ops
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NR_REQ = 2,
    parameter int XLEN   = 64,
    parameter int OP_W   = 7,
    parameter int TID_W  = 3,
    parameter int CNT_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [NR_REQ-1:0]         req_valid_i,
    output logic [NR_REQ-1:0]         req_ready_o,
    input  logic [NR_REQ*OP_W-1:0]    req_op_i,
    input  logic [NR_REQ*XLEN-1:0]    req_a_i,
    input  logic [NR_REQ*XLEN-1:0]    req_b_i,
    input  logic [NR_REQ*TID_W-1:0]   req_tid_i,
    output logic                      alu_valid_o,
    output logic [OP_W-1:0]           alu_op_o,
    output logic [XLEN-1:0]           alu_a_o,
    output logic [XLEN-1:0]           alu_b_o,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic                      alu_branch_i,
    output logic [NR_REQ-1:0]         resp_valid_o,
    input  logic [NR_REQ-1:0]         resp_ready_i,
    output logic [NR_REQ*XLEN-1:0]    resp_result_o,
    output logic [NR_REQ-1:0]         resp_branch_o,
    output logic [NR_REQ*TID_W-1:0]   resp_tid_o,
    output logic [CNT_W-1:0]          ops_count_o
);

    localparam int c_RR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [c_RR_W-1:0] r_rr;
    logic [c_RR_W-1:0] w_rr_next;
    logic [c_RR_W-1:0] w_winner;
    logic [c_RR_W-1:0] w_scan;
    logic [c_RR_W:0]   w_scan_ext;
    logic              w_grant;
    logic [NR_REQ-1:0] w_slot_full;
    logic [NR_REQ-1:0] w_eligible;
    logic [NR_REQ-1:0] w_grant_vec;
    logic [CNT_W-1:0]  r_ops_count;

    // A full slot can still accept when it is drained in the same cycle.
    // Grants are held off during reset and flush.
    assign w_eligible = req_valid_i & (~w_slot_full | resp_ready_i)
                      & {NR_REQ{rst_ni & ~flush_i}};

    // Round-robin scan starting at r_rr; the index wraps modulo NR_REQ,
    // which need not be a power of two.
    always_comb begin
        w_grant    = 1'b0;
        w_winner   = '0;
        w_scan_ext = '0;
        w_scan     = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            w_scan_ext = {1'b0, r_rr} + (c_RR_W+1)'(k);
            if (w_scan_ext >= (c_RR_W+1)'(NR_REQ)) begin
                w_scan_ext = w_scan_ext - (c_RR_W+1)'(NR_REQ);
            end
            w_scan = w_scan_ext[c_RR_W-1:0];
            if (!w_grant && w_eligible[w_scan]) begin
                w_grant  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    assign w_rr_next = (w_winner == c_RR_W'(NR_REQ - 1)) ? '0
                                                          : w_winner + c_RR_W'(1);

    // ALU drive: winner's fields, zero when idle.
    always_comb begin
        alu_valid_o = w_grant;
        alu_op_o    = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        if (w_grant) begin
            alu_op_o = req_op_i[int'(w_winner)*OP_W +: OP_W];
            alu_a_o  = req_a_i[int'(w_winner)*XLEN +: XLEN];
            alu_b_o  = req_b_i[int'(w_winner)*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_grant) begin
            r_rr <= w_rr_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ops_count <= '0;
        end else if (w_grant && (r_ops_count != {CNT_W{1'b1}})) begin
            r_ops_count <= r_ops_count + CNT_W'(1);
        end
    end

    assign ops_count_o = r_ops_count;
    assign req_ready_o = w_grant_vec;

    // Per-requester response slot: EMPTY/FULL state machine plus data.
    for (genvar i = 0; i < NR_REQ; i++) begin : g_slot
        logic [0:0]       r_state;
        logic [0:0]       w_state_next;
        logic             w_full;
        logic [XLEN-1:0]  r_result;
        logic             r_branch;
        logic [TID_W-1:0] r_tid;

        assign w_grant_vec[i] = w_grant && (w_winner == c_RR_W'(i));

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_state <= S_EMPTY;
            end else begin
                r_state <= w_state_next;
            end
        end

        // Refill takes precedence over drain so a consumed slot can be
        // reloaded in the same cycle without a bubble.
        always_comb begin
            w_state_next = r_state;
            if (flush_i) begin
                w_state_next = S_EMPTY;
            end else if (w_grant_vec[i]) begin
                w_state_next = S_FULL;
            end else if ((r_state == S_FULL) && resp_ready_i[i]) begin
                w_state_next = S_EMPTY;
            end
        end

        always_comb begin
            w_full = (r_state == S_FULL);
        end

        // Data registers hold their last value while the slot is empty.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_result <= '0;
                r_branch <= 1'b0;
                r_tid    <= '0;
            end else if (w_grant_vec[i]) begin
                r_result <= alu_result_i;
                r_branch <= alu_branch_i;
                r_tid    <= req_tid_i[i*TID_W +: TID_W];
            end
        end

        assign w_slot_full[i]                  = w_full;
        assign resp_valid_o[i]                 = w_full;
        assign resp_result_o[i*XLEN +: XLEN]   = r_result;
        assign resp_branch_o[i]                = r_branch;
        assign resp_tid_o[i*TID_W +: TID_W]    = r_tid;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Directed self-checking bench for alu_share_arbiter with two
//                requesters, a small behavioural ALU, and a 4-bit counter
//                so that saturation is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int NR  = 2;
    localparam int XL  = 64;
    localparam int OPW = 7;
    localparam int TW  = 3;
    localparam int CW  = 4;

    localparam logic [OPW-1:0] OP_ADD = 7'd0;
    localparam logic [OPW-1:0] OP_EQ  = 7'd17;
    localparam logic [OPW-1:0] OP_NE  = 7'd18;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              flush;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*OPW-1:0] req_op;
    logic [NR*XL-1:0]  req_a;
    logic [NR*XL-1:0]  req_b;
    logic [NR*TW-1:0]  req_tid;
    logic              alu_valid;
    logic [OPW-1:0]    alu_op;
    logic [XL-1:0]     alu_a;
    logic [XL-1:0]     alu_b;
    logic [XL-1:0]     alu_result;
    logic              alu_branch;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [NR*XL-1:0]  resp_result;
    logic [NR-1:0]     resp_branch;
    logic [NR*TW-1:0]  resp_tid;
    logic [CW-1:0]     ops_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .NR_REQ (NR),
        .XLEN   (XL),
        .OP_W   (OPW),
        .TID_W  (TW),
        .CNT_W  (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_a_i       (req_a),
        .req_b_i       (req_b),
        .req_tid_i     (req_tid),
        .alu_valid_o   (alu_valid),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_result_i  (alu_result),
        .alu_branch_i  (alu_branch),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .resp_branch_o (resp_branch),
        .resp_tid_o    (resp_tid),
        .ops_count_o   (ops_count)
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        alu_result = '0;
        alu_branch = 1'b0;
        case (alu_op)
            OP_ADD: alu_result = alu_a + alu_b;
            OP_EQ: begin
                alu_branch = (alu_a == alu_b);
                alu_result = {63'd0, (alu_a == alu_b)};
            end
            OP_NE: begin
                alu_branch = (alu_a != alu_b);
                alu_result = {63'd0, (alu_a != alu_b)};
            end
            default: ;
        endcase
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [OPW-1:0] op,
                           input logic [XL-1:0] a, input logic [XL-1:0] b,
                           input logic [TW-1:0] tid);
        req_op[idx*OPW +: OPW] = op;
        req_a[idx*XL +: XL]    = a;
        req_b[idx*XL +: XL]    = b;
        req_tid[idx*TW +: TW]  = tid;
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_tid    = '0;
        tick();
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b exp 00", resp_valid); end
        checks++; if (ops_count !== 4'd0) begin errors++; $display("FAIL reset_ops: got %0d exp 0", ops_count); end
        checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %b exp 0", alu_valid); end
        checks++; if (resp_result !== '0) begin errors++; $display("FAIL reset_result: got %h exp 0", resp_result); end
        checks++; if (resp_tid !== '0 || resp_branch !== '0) begin errors++; $display("FAIL reset_tid_branch: got %h/%b exp 0/0", resp_tid, resp_branch); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_op();
        set_req(0, OP_ADD, 64'd5, 64'd7, 3'd3);
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", req_ready); end
        checks++; if (alu_valid !== 1'b1 || alu_op !== OP_ADD) begin errors++; $display("FAIL single_alu_valid_op: got %b/%0d exp 1/0", alu_valid, alu_op); end
        checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7) begin errors++; $display("FAIL single_alu_ab: got %0d/%0d exp 5/7", alu_a, alu_b); end
        tick();
        req_valid = 2'b00;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid: got %b exp 01", resp_valid); end
        checks++; if (resp_result[63:0] !== 64'd12) begin errors++; $display("FAIL single_result: got %0d exp 12", resp_result[63:0]); end
        checks++; if (resp_tid[2:0] !== 3'd3) begin errors++; $display("FAIL single_tid: got %0d exp 3", resp_tid[2:0]); end
        checks++; if (ops_count !== 4'd1) begin errors++; $display("FAIL single_ops: got %0d exp 1", ops_count); end
        resp_ready = 2'b01;
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_drain: got %b exp 00", resp_valid); end
        checks++; if (resp_result[63:0] !== 64'd12) begin errors++; $display("FAIL single_hold: got %0d exp 12", resp_result[63:0]); end
        resp_ready = 2'b00;
    endtask

    // Pointer is at 1 here, so grants go 1,0,1,0.
    task automatic test_contention();
        logic [1:0] exp;
        set_req(0, OP_ADD, 64'd10, 64'd1, 3'd1);
        set_req(1, OP_ADD, 64'd20, 64'd2, 3'd2);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL cont_ready[%0d]: got %b exp %b", k, req_ready, exp); end
            tick();
            checks++; if (resp_valid !== exp) begin errors++; $display("FAIL cont_resp_valid[%0d]: got %b exp %b", k, resp_valid, exp); end
            if (exp == 2'b10) begin
                checks++; if (resp_result[127:64] !== 64'd22) begin errors++; $display("FAIL cont_result1[%0d]: got %0d exp 22", k, resp_result[127:64]); end
            end else begin
                checks++; if (resp_result[63:0] !== 64'd11) begin errors++; $display("FAIL cont_result0[%0d]: got %0d exp 11", k, resp_result[63:0]); end
            end
        end
        checks++; if (ops_count !== 4'd5) begin errors++; $display("FAIL cont_ops: got %0d exp 5", ops_count); end
        req_valid = 2'b00;
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL cont_drain: got %b exp 00", resp_valid); end
        resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        set_req(0, OP_ADD, 64'd100, 64'd1, 3'd1);
        req_valid = 2'b01;
        tick();
        set_req(1, OP_ADD, 64'd200, 64'd3, 3'd2);
        req_valid = 2'b11;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL bp_fill0: got %b exp 01", resp_valid); end
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_only1: got %b exp 10", req_ready); end
        tick();
        checks++; if (resp_valid !== 2'b11) begin errors++; $display("FAIL bp_both_full: got %b exp 11", resp_valid); end
        checks++; if (resp_result[127:64] !== 64'd203) begin errors++; $display("FAIL bp_result1: got %0d exp 203", resp_result[127:64]); end
        set_req(0, OP_ADD, 64'd300, 64'd4, 3'd5);
        resp_ready = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_refill_ready: got %b exp 01", req_ready); end
        tick();
        checks++; if (resp_valid !== 2'b11) begin errors++; $display("FAIL bp_refill_valid: got %b exp 11", resp_valid); end
        checks++; if (resp_result[63:0] !== 64'd304 || resp_tid[2:0] !== 3'd5) begin errors++; $display("FAIL bp_refill_data: got %0d/%0d exp 304/5", resp_result[63:0], resp_tid[2:0]); end
        checks++; if (ops_count !== 4'd8) begin errors++; $display("FAIL bp_ops: got %0d exp 8", ops_count); end
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic test_branch();
        set_req(1, OP_EQ, 64'hDEAD, 64'hDEAD, 3'd4);
        req_valid = 2'b10;
        tick();
        checks++; if (resp_branch[1] !== 1'b1 || resp_result[127:64] !== 64'd1) begin errors++; $display("FAIL br_eq: got %b/%0d exp 1/1", resp_branch[1], resp_result[127:64]); end
        set_req(1, OP_NE, 64'hDEAD, 64'hDEAD, 3'd6);
        resp_ready = 2'b10;
        tick();
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL br_ne_valid: got %b exp 10", resp_valid); end
        checks++; if (resp_branch[1] !== 1'b0 || resp_result[127:64] !== 64'd0) begin errors++; $display("FAIL br_ne: got %b/%0d exp 0/0", resp_branch[1], resp_result[127:64]); end
        checks++; if (resp_tid[5:3] !== 3'd6) begin errors++; $display("FAIL br_tid: got %0d exp 6", resp_tid[5:3]); end
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        tick();
        resp_ready = 2'b00;
    endtask

    // Fill order 1 then 0 leaves the pointer at 1 going into the flush.
    task automatic test_flush();
        set_req(1, OP_ADD, 64'd1, 64'd1, 3'd1);
        req_valid = 2'b10;
        tick();
        set_req(0, OP_ADD, 64'd2, 64'd2, 3'd2);
        req_valid = 2'b01;
        tick();
        checks++; if (resp_valid !== 2'b11) begin errors++; $display("FAIL fl_full: got %b exp 11", resp_valid); end
        checks++; if (ops_count !== 4'd12) begin errors++; $display("FAIL fl_ops_pre: got %0d exp 12", ops_count); end
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        flush      = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fl_ready: got %b exp 00", req_ready); end
        checks++; if (alu_valid !== 1'b0 || alu_a !== 64'd0) begin errors++; $display("FAIL fl_alu: got %b/%0d exp 0/0", alu_valid, alu_a); end
        tick();
        flush      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL fl_empty: got %b exp 00", resp_valid); end
        checks++; if (ops_count !== 4'd12) begin errors++; $display("FAIL fl_ops_hold: got %0d exp 12", ops_count); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL fl_rr_hold: got %b exp 10", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b01;
        tick();
        checks++; if (resp_valid !== 2'b11) begin errors++; $display("FAIL rm_full: got %b exp 11", resp_valid); end
        rst_ni    = 1'b0;
        req_valid = 2'b00;
        tick();
        rst_ni = 1'b1;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rm_valid: got %b exp 00", resp_valid); end
        checks++; if (ops_count !== 4'd0) begin errors++; $display("FAIL rm_ops: got %0d exp 0", ops_count); end
        checks++; if (resp_result !== '0) begin errors++; $display("FAIL rm_result: got %h exp 0", resp_result); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b exp 01", req_ready); end
        req_valid = 2'b00;
    endtask

    // Both continuously eligible: strict alternation and counter saturation at 15.
    task automatic test_saturate();
        logic [1:0]    exp;
        logic [CW-1:0] exp_ops;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 20; k++) begin
            exp     = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_ops = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            #1;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL sat_ready[%0d]: got %b exp %b", k, req_ready, exp); end
            tick();
            checks++; if (ops_count !== exp_ops) begin errors++; $display("FAIL sat_ops[%0d]: got %0d exp %0d", k, ops_count, exp_ops); end
        end
        req_valid  = 2'b00;
        tick();
        resp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_branch();
        test_flush();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
